// File: rtl/fft_in_frame_buf.sv
// Ping-pong input frame buffer: collects 512 complex samples per bank and replays each
// frame as 32 contiguous 16-lane beats. Optional frame-marker checking via FFT_INBUF_LAST_CHK_EN.
module fft_in_frame_buf #(
  parameter int WIDTH = 9,
  parameter int LANES = 16,
  parameter int NFFT  = 512
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [WIDTH-1:0]       s_i,
  input  logic [WIDTH-1:0]       s_q,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_last,
  input  logic                   out_go,
  output logic [LANES*WIDTH-1:0] out_i,
  output logic [LANES*WIDTH-1:0] out_q,
  output logic                   dout_valid,
  output logic                   frame_done,
  output logic                   sync_err
);
  // state    | meaning
  // ST_IDLE  | waiting for a full read bank and out_go
  // ST_BURST | emitting beats of bank rb, one per cycle, never interrupted

  localparam int BEATS = NFFT / LANES;
  localparam int WC_W  = $clog2(NFFT);
  localparam int RC_W  = $clog2(BEATS);
  localparam int LN_W  = $clog2(LANES);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  if (LANES != 16) begin : g_lanes_chk
    $error("fft_in_frame_buf: LANES must be 16");
  end
  if (NFFT != 512) begin : g_nfft_chk
    $error("fft_in_frame_buf: NFFT must be 512");
  end

  logic [2*WIDTH-1:0]     mem [2][BEATS][LANES];

  logic [0:0]             state_q, state_d;
  logic [WC_W-1:0]        wr_cnt_q, wr_cnt_d;
  logic [RC_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic                   wb_q, wb_d;
  logic                   rb_q, rb_d;
  logic [1:0]             bank_full_q, bank_full_d;
  logic                   dout_valid_q, dout_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   sync_err_q, sync_err_d;
  logic [LANES*WIDTH-1:0] out_i_q, out_i_d;
  logic [LANES*WIDTH-1:0] out_q_q, out_q_d;

  logic                   xfer;
  logic                   wr_last;
  logic                   rd_last;
  logic                   rb_other;
  logic                   set_full;
  logic                   clr_full;
  logic [2*WIDTH-1:0]     rd_word;

  // Ready depends on registered bank state only, so out_go never reaches s_ready.
  assign s_ready  = rstn & ~bank_full_q[wb_q];
  assign xfer     = s_valid & s_ready;
  assign wr_last  = (wr_cnt_q == WC_W'(NFFT - 1));
  assign rd_last  = (rd_cnt_q == RC_W'(BEATS - 1));
  assign rb_other = ~rb_q;

`ifndef FFT_INBUF_LAST_CHK_EN
  logic s_last_unused;
  assign s_last_unused = s_last;
`endif

  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    wb_d         = wb_q;
    rb_d         = rb_q;
    bank_full_d  = bank_full_q;
    dout_valid_d = 1'b0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    out_i_d      = '0;
    out_q_d      = '0;
    set_full     = 1'b0;
    clr_full     = 1'b0;
    rd_word      = '0;

    if (xfer) begin
`ifdef FFT_INBUF_LAST_CHK_EN
      if (s_last && !wr_last) begin
        wr_cnt_d   = '0;
        sync_err_d = 1'b1;
      end else if (wr_last) begin
        set_full   = 1'b1;
        wr_cnt_d   = '0;
        sync_err_d = ~s_last;
      end else begin
        wr_cnt_d = wr_cnt_q + WC_W'(1);
      end
`else
      if (wr_last) begin
        set_full = 1'b1;
        wr_cnt_d = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + WC_W'(1);
      end
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rb_q] && out_go) begin
          state_d  = ST_BURST;
          rd_cnt_d = '0;
        end
      end
      default: begin
        dout_valid_d = 1'b1;
        for (int k = 0; k < LANES; k++) begin
          rd_word = mem[rb_q][rd_cnt_q][k];
          out_i_d[k*WIDTH +: WIDTH] = rd_word[2*WIDTH-1:WIDTH];
          out_q_d[k*WIDTH +: WIDTH] = rd_word[WIDTH-1:0];
        end
        rd_cnt_d = rd_cnt_q + RC_W'(1);
        if (rd_last) begin
          frame_done_d = 1'b1;
          clr_full     = 1'b1;
          rb_d         = rb_other;
          rd_cnt_d     = '0;
          // Chain straight into the other bank when it is ready, giving zero gap.
          if (!(bank_full_q[rb_other] && out_go)) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase

    // Freeing and committing always target different banks, so both apply.
    if (clr_full) begin
      bank_full_d[rb_q] = 1'b0;
    end
    if (set_full) begin
      bank_full_d[wb_q] = 1'b1;
      wb_d              = ~wb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wb_q         <= 1'b0;
      rb_q         <= 1'b0;
      bank_full_q  <= '0;
      dout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wb_q         <= wb_d;
      rb_q         <= rb_d;
      bank_full_q  <= bank_full_d;
      dout_valid_q <= dout_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
    end
  end

  // Sample storage is not reset; bank_full gates every read.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[wb_q][wr_cnt_q[WC_W-1:LN_W]][wr_cnt_q[LN_W-1:0]] <= {s_i, s_q};
    end
  end

  assign out_i      = out_i_q;
  assign out_q      = out_q_q;
  assign dout_valid = dout_valid_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule
